ccu_cmd_sched: RTL

Two-requester command scheduler in front of the CCU. It accepts 8-bit CCU command bytes from two independent sources (host interface and blitter engine) over valid/ready handshakes. It arbitrates between them and drives the CCU `cmd` input, holding each command for a requester-specified number of cycles and inserting one NOP cycle between commands. It owns the only path onto the CCU command bus; the CCU's `Kbus` output is not observed by this block.

---
 rtl/ccu_cmd_sched.sv | 92 +++++++++
 1 files changed

// File: rtl/ccu_cmd_sched.sv
// Two-requester command scheduler driving the CCU command bus.
// Optional macro CCU_SCHED_PRIO_EN selects fixed priority (requester 0 wins) over round-robin.
module ccu_cmd_sched #(
    parameter logic [7:0] NOP_CMD = 8'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_cmd,
    input  logic [2:0]  req0_len,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_cmd,
    input  logic [2:0]  req1_len,
    output logic [7:0]  ccu_cmd,
    output logic        busy,
    output logic        grant_id,
    output logic [15:0] issued_cnt
);

    typedef enum logic [1:0] {StIdle, StHold, StGap} state_e;

    state_e     state_q;
    logic [2:0] hold_cnt_q;
    logic       last_grant_q;

    logic       can_accept;
    logic       winner;
    logic       accept;
    logic [7:0] win_cmd;
    logic [2:0] win_len;

    always_comb begin
        can_accept = rst_n && ((state_q == StIdle) || (state_q == StGap));
`ifdef CCU_SCHED_PRIO_EN
        winner = ~req0_valid;
`else
        // On a tie the requester that did not win last time gets the bus.
        if (req0_valid && req1_valid) begin
            winner = ~last_grant_q;
        end else begin
            winner = ~req0_valid;
        end
`endif
        req0_ready = can_accept && req0_valid && !winner;
        req1_ready = can_accept && req1_valid && winner;
        accept     = req0_ready || req1_ready;
        win_cmd    = winner ? req1_cmd : req0_cmd;
        win_len    = winner ? req1_len : req0_len;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            hold_cnt_q   <= 3'd0;
            last_grant_q <= 1'b1;
            ccu_cmd      <= NOP_CMD;
            busy         <= 1'b0;
            grant_id     <= 1'b0;
            issued_cnt   <= 16'd0;
        end else begin
            case (state_q)
                StHold: begin
                    if (hold_cnt_q == 3'd0) begin
                        state_q <= StGap;
                        ccu_cmd <= NOP_CMD;
                        busy    <= 1'b0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q - 3'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        state_q      <= StHold;
                        hold_cnt_q   <= win_len;
                        last_grant_q <= winner;
                        grant_id     <= winner;
                        ccu_cmd      <= win_cmd;
                        busy         <= 1'b1;
                        issued_cnt   <= issued_cnt + 16'd1;
                    end else begin
                        state_q <= StIdle;
                        ccu_cmd <= NOP_CMD;
                        busy    <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
